crc40_packer: RTL and testbench
===============================

CRC40_PACKER -- requirements
Module: crc40_packer

Interface
REQ-001 SHALL provide the ports below, clock and reset first; reset rst, asynchronous, active-high; clock clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_data  input  8  frame byte.
REQ-005 in_valid  input  1  in_data/in_sof/in_eof qualified this cycle; one byte per cycle max, no backpressure.
REQ-006 in_sof  input  1  byte is first of frame.
REQ-007 in_eof  input  1  byte is last of frame.
REQ-008 out_data  output  40  packed word for downstream CRC-40-input stage.
REQ-009 out_valid  output  1  one-cycle pulse per word; drives downstream crc_en.
REQ-010 out_last  output  1  word is last of frame, coincident with out_valid.
REQ-011 out_nbytes  output  3  valid bytes in out_data (1..5), meaningful with out_valid.
REQ-012 crc_init  output  1  registered one-cycle pulse on frame start; drives downstream CRC reset to all-ones.
REQ-013 frame_len  output  16  byte count of frame, updated with out_last, held otherwise.
REQ-014 err  output  1  one-cycle pulse on protocol error.

Function
REQ-015 SHALL implement states IDLE and ACC plus 3-bit byte counter cnt (0..4) and 40-bit accumulator.
REQ-016 IDLE: in_valid&in_sof accepts byte into lane 0, cnt=1, len=1, crc_init=1 next cycle, go ACC.
REQ-017 IDLE: in_valid without in_sof SHALL drop byte and pulse err next cycle.
REQ-018 ACC: in_valid&!in_sof stores byte in lane cnt, increments cnt and len (len saturates at 0xFFFF).
REQ-019 When the 5th byte is accepted, out_data SHALL present the word with out_valid=1, out_nbytes=5 the following cycle; cnt wraps to 0.
REQ-020 When the in_eof byte is accepted, the word (partial or full) SHALL be emitted next cycle with out_last=1, out_nbytes=cnt+1 (1..5), frame_len=final len; unfilled lanes zero; return IDLE.
REQ-021 in_sof&in_eof together in IDLE: single-byte frame; crc_init and out_valid/out_last (nbytes=1) both asserted next cycle.
REQ-022 in_sof in ACC: current partial frame discarded (no word emitted), err pulsed, byte treated as new frame start per REQ-016.
REQ-023 Latency byte-accept to out_valid SHALL be exactly 1 cycle; out_valid SHALL never be high two consecutive cycles unless consecutive eof/5th-byte events occur.
REQ-024 out_data SHALL hold last emitted value when out_valid=0.
REQ-025 cycles with in_valid=0 SHALL not change state.

Reset
REQ-026 rst SHALL asynchronously force state IDLE, cnt=0, len=0, accumulator=0, out_data=0, out_valid=0, out_last=0, out_nbytes=0, crc_init=0, frame_len=0, err=0.
REQ-027 rst mid-frame SHALL discard partial frame; no word emitted after release until new sof.

Configuration
REQ-028 Macro CRC40_PACKER_MSB_FIRST_EN: defined -> first frame byte in out_data[39:32], lane k at [39-8k:32-8k], unfilled low lanes zero.
REQ-029 Not defined -> first byte in out_data[7:0], lane k at [8k+7:8k], unfilled high lanes zero.

Verification
REQ-030 LSB-first, 10 bytes 0x01..0x0A sof/eof, back-to-back -> crc_init 1 cycle after byte 1; words 0x0504030201 (nbytes 5) and 0x0A09080706 (last, nbytes 5); frame_len=10.
REQ-031 7-byte frame 0x11..0x17 -> words 0x1514131211 then 0x0000001716 (last, nbytes 2), frame_len=7; MSB_FIRST build: 0x1112131415 then 0x1617000000.
REQ-032 Single byte 0xAB with sof&eof -> next cycle crc_init=1, out_valid=1, out_last=1, out_nbytes=1, out_data=0x00000000AB (LSB build).
REQ-033 3 bytes then sof mid-frame, then 5-byte frame -> err pulse, no partial word, then one full word last nbytes 5.
REQ-034 Byte without sof in IDLE -> err pulse, no out_valid; rst asserted after 2 bytes of frame -> all outputs zero, subsequent frame packs from lane 0.
REQ-035 in_valid gaps (valid every 3rd cycle) over 6-byte frame -> identical words to back-to-back case, each 1 cycle after completing byte.

Source files
------------

// File: rtl/crc40_packer.sv
// Packs a byte stream into 40-bit words for a downstream CRC-40 stage, with frame length and error pulses.
// Build option CRC40_PACKER_MSB_FIRST_EN: first byte lands in out_data[39:32] instead of out_data[7:0].
module crc40_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic [39:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic [2:0]  out_nbytes,
    output logic        crc_init,
    output logic [15:0] frame_len,
    output logic        err
);

    localparam int unsigned W_BYTE  = 8;
    localparam int unsigned W_WORD  = 40;
    localparam int unsigned W_LEN   = 16;
    localparam int unsigned W_CNT   = 3;
    localparam int unsigned W_SHIFT = 6;
    localparam logic [W_CNT-1:0] LAST_LANE = W_CNT'(4);

    typedef enum logic {
        ST_IDLE,
        ST_ACC
    } state_t;

    state_t              state_q;
    logic [W_CNT-1:0]    cnt_q;
    logic [W_LEN-1:0]    len_q;
    logic [W_WORD-1:0]   acc_q;
    logic [W_WORD-1:0]   out_data_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic [W_CNT-1:0]    out_nbytes_q;
    logic                crc_init_q;
    logic [W_LEN-1:0]    frame_len_q;
    logic                err_q;

    logic                start_c;
    logic [W_CNT-1:0]    lane_c;
    logic [W_SHIFT-1:0]  shift_c;
    logic [W_WORD-1:0]   word_d;
    logic [W_LEN-1:0]    len_d;
    logic [W_CNT-1:0]    nbytes_c;

    // Merge the incoming byte into its lane; a start of frame always begins from an empty word.
    always_comb begin
        start_c  = in_valid && in_sof;
        lane_c   = start_c ? W_CNT'(0) : cnt_q;
`ifdef CRC40_PACKER_MSB_FIRST_EN
        shift_c  = W_SHIFT'(32) - {lane_c, 3'b000};
`else
        shift_c  = {lane_c, 3'b000};
`endif
        word_d   = (start_c ? W_WORD'(0) : acc_q) | (W_WORD'(in_data) << shift_c);
        len_d    = (len_q == {W_LEN{1'b1}}) ? len_q : len_q + W_LEN'(1);
        nbytes_c = lane_c + W_CNT'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            acc_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_nbytes_q <= '0;
            crc_init_q   <= 1'b0;
            frame_len_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            crc_init_q  <= 1'b0;
            err_q       <= 1'b0;
            if (in_valid) begin
                if (start_c) begin
                    // A sof inside a frame abandons the partial word without emitting it.
                    err_q      <= (state_q == ST_ACC);
                    crc_init_q <= 1'b1;
                    len_q      <= W_LEN'(1);
                    if (in_eof) begin
                        out_data_q   <= word_d;
                        out_valid_q  <= 1'b1;
                        out_last_q   <= 1'b1;
                        out_nbytes_q <= nbytes_c;
                        frame_len_q  <= W_LEN'(1);
                        acc_q        <= '0;
                        cnt_q        <= '0;
                        state_q      <= ST_IDLE;
                    end else begin
                        acc_q   <= word_d;
                        cnt_q   <= W_CNT'(1);
                        state_q <= ST_ACC;
                    end
                end else if (state_q == ST_IDLE) begin
                    err_q <= 1'b1;
                end else begin
                    len_q <= len_d;
                    if (in_eof) begin
                        out_data_q   <= word_d;
                        out_valid_q  <= 1'b1;
                        out_last_q   <= 1'b1;
                        out_nbytes_q <= nbytes_c;
                        frame_len_q  <= len_d;
                        acc_q        <= '0;
                        cnt_q        <= '0;
                        state_q      <= ST_IDLE;
                    end else if (cnt_q == LAST_LANE) begin
                        out_data_q   <= word_d;
                        out_valid_q  <= 1'b1;
                        out_nbytes_q <= nbytes_c;
                        acc_q        <= '0;
                        cnt_q        <= '0;
                    end else begin
                        acc_q <= word_d;
                        cnt_q <= cnt_q + W_CNT'(1);
                    end
                end
            end
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_nbytes = out_nbytes_q;
    assign crc_init   = crc_init_q;
    assign frame_len  = frame_len_q;
    assign err        = err_q;

endmodule

// File: tb/tb_crc40_packer.sv
// Directed bench for crc40_packer: packing, frame length, error pulses, reset and valid gaps.
module tb_crc40_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sof;
    logic        in_eof;
    logic [39:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [2:0]  out_nbytes;
    logic        crc_init;
    logic [15:0] frame_len;
    logic        err;

    int checks = 0;
    int errors = 0;

    crc40_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_eof     (in_eof),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_nbytes (out_nbytes),
        .crc_init   (crc_init),
        .frame_len  (frame_len),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected values below are written for the LSB-first layout; the MSB-first build mirrors the lanes.
    function automatic logic [39:0] exp_w(input logic [39:0] lsb);
`ifdef CRC40_PACKER_MSB_FIRST_EN
        return {lsb[7:0], lsb[15:8], lsb[23:16], lsb[31:24], lsb[39:32]};
`else
        return lsb;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic l, input logic [2:0] nb,
                           input logic [39:0] d, input logic ci, input logic e, input logic [15:0] fl);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".last"}, 64'(out_last), 64'(l));
        if (v) chk({tag, ".nbytes"}, 64'(out_nbytes), 64'(nb));
        chk({tag, ".data"}, 64'(out_data), 64'(d));
        chk({tag, ".crc_init"}, 64'(crc_init), 64'(ci));
        chk({tag, ".err"}, 64'(err), 64'(e));
        chk({tag, ".frame_len"}, 64'(frame_len), 64'(fl));
    endtask

    task automatic send(input logic [7:0] d, input logic s, input logic e);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        in_sof   = s;
        in_eof   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        in_data  = 8'hEE;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        #1;
        chk_out("reset", 1'b0, 1'b0, 3'd0, 40'h0, 1'b0, 1'b0, 16'd0);
        chk("reset.nbytes", 64'(out_nbytes), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk_out("post_reset_idle", 1'b0, 1'b0, 3'd0, 40'h0, 1'b0, 1'b0, 16'd0);

        // 10-byte back-to-back frame
        send(8'h01, 1'b1, 1'b0);
        chk_out("f10.b1", 1'b0, 1'b0, 3'd0, 40'h0, 1'b1, 1'b0, 16'd0);
        send(8'h02, 1'b0, 1'b0);
        chk_out("f10.b2", 1'b0, 1'b0, 3'd0, 40'h0, 1'b0, 1'b0, 16'd0);
        send(8'h03, 1'b0, 1'b0);
        send(8'h04, 1'b0, 1'b0);
        send(8'h05, 1'b0, 1'b0);
        chk_out("f10.w1", 1'b1, 1'b0, 3'd5, exp_w(40'h0504030201), 1'b0, 1'b0, 16'd0);
        send(8'h06, 1'b0, 1'b0);
        chk_out("f10.b6", 1'b0, 1'b0, 3'd0, exp_w(40'h0504030201), 1'b0, 1'b0, 16'd0);
        send(8'h07, 1'b0, 1'b0);
        send(8'h08, 1'b0, 1'b0);
        send(8'h09, 1'b0, 1'b0);
        send(8'h0A, 1'b0, 1'b1);
        chk_out("f10.w2", 1'b1, 1'b1, 3'd5, exp_w(40'h0A09080706), 1'b0, 1'b0, 16'd10);
        idle();
        chk_out("f10.hold", 1'b0, 1'b0, 3'd0, exp_w(40'h0A09080706), 1'b0, 1'b0, 16'd10);

        // 7-byte frame: full word then 2-byte tail
        send(8'h11, 1'b1, 1'b0);
        chk_out("f7.b1", 1'b0, 1'b0, 3'd0, exp_w(40'h0A09080706), 1'b1, 1'b0, 16'd10);
        send(8'h12, 1'b0, 1'b0);
        send(8'h13, 1'b0, 1'b0);
        send(8'h14, 1'b0, 1'b0);
        send(8'h15, 1'b0, 1'b0);
        chk_out("f7.w1", 1'b1, 1'b0, 3'd5, exp_w(40'h1514131211), 1'b0, 1'b0, 16'd10);
        send(8'h16, 1'b0, 1'b0);
        send(8'h17, 1'b0, 1'b1);
        chk_out("f7.w2", 1'b1, 1'b1, 3'd2, exp_w(40'h0000001716), 1'b0, 1'b0, 16'd7);

        // single-byte frame immediately after
        send(8'hAB, 1'b1, 1'b1);
        chk_out("f1", 1'b1, 1'b1, 3'd1, exp_w(40'h00000000AB), 1'b1, 1'b0, 16'd1);
        idle();
        chk_out("f1.after", 1'b0, 1'b0, 3'd0, exp_w(40'h00000000AB), 1'b0, 1'b0, 16'd1);

        // sof in mid-frame discards the partial frame
        send(8'h21, 1'b1, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h23, 1'b0, 1'b0);
        chk_out("abort.b3", 1'b0, 1'b0, 3'd0, exp_w(40'h00000000AB), 1'b0, 1'b0, 16'd1);
        send(8'h31, 1'b1, 1'b0);
        chk_out("abort.sof", 1'b0, 1'b0, 3'd0, exp_w(40'h00000000AB), 1'b1, 1'b1, 16'd1);
        send(8'h32, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        send(8'h34, 1'b0, 1'b0);
        send(8'h35, 1'b0, 1'b1);
        chk_out("abort.w", 1'b1, 1'b1, 3'd5, exp_w(40'h3534333231), 1'b0, 1'b0, 16'd5);

        // byte without sof in IDLE is dropped
        send(8'h55, 1'b0, 1'b0);
        chk_out("nosof", 1'b0, 1'b0, 3'd0, exp_w(40'h3534333231), 1'b0, 1'b1, 16'd5);
        idle();
        chk_out("nosof.after", 1'b0, 1'b0, 3'd0, exp_w(40'h3534333231), 1'b0, 1'b0, 16'd5);

        // asynchronous reset mid-frame
        send(8'h41, 1'b1, 1'b0);
        send(8'h42, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_out("midrst", 1'b0, 1'b0, 3'd0, 40'h0, 1'b0, 1'b0, 16'd0);
        chk("midrst.nbytes", 64'(out_nbytes), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h60, 1'b0, 1'b1);
        chk_out("midrst.nosof", 1'b0, 1'b0, 3'd0, 40'h0, 1'b0, 1'b1, 16'd0);
        send(8'h61, 1'b1, 1'b0);
        send(8'h62, 1'b0, 1'b1);
        chk_out("midrst.new", 1'b1, 1'b1, 3'd2, exp_w(40'h0000006261), 1'b0, 1'b0, 16'd2);

        // 6-byte frame with valid every third cycle
        send(8'h71, 1'b1, 1'b0);
        chk_out("gap.b1", 1'b0, 1'b0, 3'd0, exp_w(40'h0000006261), 1'b1, 1'b0, 16'd2);
        for (int i = 2; i <= 6; i++) begin
            idle();
            idle();
            send(8'(8'h70 + i), 1'b0, (i == 6));
            if (i == 5) begin
                chk_out("gap.w1", 1'b1, 1'b0, 3'd5, exp_w(40'h7574737271), 1'b0, 1'b0, 16'd2);
                idle();
                chk_out("gap.hold", 1'b0, 1'b0, 3'd0, exp_w(40'h7574737271), 1'b0, 1'b0, 16'd2);
            end else if (i == 6) begin
                chk_out("gap.w2", 1'b1, 1'b1, 3'd1, exp_w(40'h0000000076), 1'b0, 1'b0, 16'd6);
            end else begin
                chk_out("gap.mid", 1'b0, 1'b0, 3'd0, exp_w(40'h0000006261), 1'b0, 1'b0, 16'd2);
            end
        end
        idle();
        chk_out("end", 1'b0, 1'b0, 3'd0, exp_w(40'h0000000076), 1'b0, 1'b0, 16'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
